// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: encodings shared by the RAM access arbiter and its wait-state counter.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_LS  = 1'b1;
    localparam logic [3:0] BE_WORD = 4'hF;

    // Wide enough for latencies and streak limits up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/ram_wait_counter.sv
// ram_wait_counter: loadable down-counter that stops at zero and flags it,
// usable for any RAM or peripheral wait-state sequencing.
module ram_wait_counter
    import rv_mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // A load wins over a decrement; the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares the single RAM port between instruction fetch (IF) and
// load/store (LS), holding the strobes for RAM_LATENCY cycles and returning the word.
module ram_access_arbiter
    import rv_mem_pkg::*;
#(
    parameter int RAM_LATENCY   = 2,
    parameter int ADDR_W        = 8,
    parameter int LS_MAX_STREAK = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iIF_REQ,
    input  logic [31:0]       iIF_ADDR,
    output logic              oIF_ACK,
    output logic [31:0]       oIF_DATA,
    input  logic              iLS_REQ,
    input  logic              iLS_WR,
    input  logic [31:0]       iLS_ADDR,
    input  logic [31:0]       iLS_WDATA,
    input  logic [3:0]        iLS_BE,
    output logic              oLS_ACK,
    output logic [31:0]       oLS_RDATA,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [31:0]       oRAM_WDATA,
    output logic [3:0]        oRAM_BE,
    input  logic [31:0]       iRAM_DATA,
    output logic              oBUSY
);

    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RAM_LATENCY - 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(LS_MAX_STREAK);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  streak_q, streak_d;
    logic              ce_q, ce_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              if_ack_q, if_ack_d, ls_ack_q, ls_ack_d;
    logic [31:0]       if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
    logic              grant_ls, cnt_load, cnt_dec, cnt_zero;
    logic              unused_addr_bits;

    // Byte-offset and out-of-range address bits are intentionally dropped.
    assign unused_addr_bits = ^{iIF_ADDR[31:ADDR_W+2], iIF_ADDR[1:0],
                                iLS_ADDR[31:ADDR_W+2], iLS_ADDR[1:0]};

    ram_wait_counter #(.W(CNT_W)) u_wait (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            streak_q   <= '0;
            ce_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            ce_q       <= ce_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // LS normally wins; once it has taken STREAK_MAX grants in a row over a
    // waiting fetch, the fetch is forced through so the core cannot starve.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        ce_d       = ce_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        grant_ls   = iLS_REQ && !(iIF_REQ && (streak_q == STREAK_MAX));

        unique case (state_q)
            IDLE: begin
                if (iIF_REQ || iLS_REQ) begin
                    state_d  = ACCESS;
                    cnt_load = 1'b1;
                    ce_d     = 1'b1;
                    if (grant_ls) begin
                        owner_d  = OWN_LS;
                        streak_d = iIF_REQ ? streak_q + 1'b1 : '0;
                        addr_d   = iLS_ADDR[ADDR_W+1:2];
                        wr_d     = iLS_WR;
                        rd_d     = !iLS_WR;
                        wdata_d  = iLS_WDATA;
                        be_d     = iLS_WR ? iLS_BE : BE_WORD;
                    end else begin
                        owner_d  = OWN_IF;
                        streak_d = '0;
                        addr_d   = iIF_ADDR[ADDR_W+1:2];
                        wr_d     = 1'b0;
                        rd_d     = 1'b1;
                        wdata_d  = '0;
                        be_d     = BE_WORD;
                    end
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = RESP;
                    ce_d    = 1'b0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                    if (owner_q == OWN_LS) begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = wr_q ? 32'h0 : iRAM_DATA;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = iRAM_DATA;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oIF_ACK    = if_ack_q;
    assign oIF_DATA   = if_data_q;
    assign oLS_ACK    = ls_ack_q;
    assign oLS_RDATA  = ls_rdata_q;
    assign oRAM_CE    = ce_q;
    assign oRAM_RD    = rd_q;
    assign oRAM_WR    = wr_q;
    assign oRAM_ADDR  = addr_q;
    assign oRAM_WDATA = wdata_q;
    assign oRAM_BE    = be_q;
    assign oBUSY      = (state_q != IDLE);

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Shares the single data/instruction RAM port between the instruction-fetch stage (IF) and the load/store path of the I-type/S-type execution units (LS).
- Serialises requests with a req/ack handshake.
- Holds RAM control stable for a parameterised number of wait cycles, then returns the read word to the winning requester.
- Sits between the core datapath and the RAM; it replaces the hard-tied CE/RD/WR strobes in the datapath.

Parameters:
- RAM_LATENCY, 2, cycles the RAM signals are held asserted per access (legal range 1..15).
- ADDR_W, 8, width of the word address driven to the RAM.
- LS_MAX_STREAK, 4, consecutive LS grants allowed while IF is pending before IF is forced (legal range 1..15).

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  asynchronous reset, active high.
- iIF_REQ  in  1  fetch request, held until oIF_ACK.
- iIF_ADDR  in  32  fetch byte address.
- oIF_ACK  out  1  one-cycle pulse; oIF_DATA is valid in that cycle.
- oIF_DATA  out  32  fetched word.
- iLS_REQ  in  1  load/store request, held until oLS_ACK.
- iLS_WR  in  1  1 = store, 0 = load.
- iLS_ADDR  in  32  load/store byte address.
- iLS_WDATA  in  32  store data.
- iLS_BE  in  4  store byte enables.
- oLS_ACK  out  1  one-cycle completion pulse.
- oLS_RDATA  out  32  load word; 0 for stores.
- oRAM_CE  out  1  RAM chip enable.
- oRAM_RD  out  1  RAM read strobe.
- oRAM_WR  out  1  RAM write strobe.
- oRAM_ADDR  out  ADDR_W  word address = byte_addr[ADDR_W+1:2].
- oRAM_WDATA  out  32  write data.
- oRAM_BE  out  4  byte enables; 4'hF for reads.
- iRAM_DATA  in  32  RAM read data, valid in the last access cycle.
- oBUSY  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, iRST=1): state IDLE; all outputs 0; wait counter 0; streak counter 0; owner register cleared. An access interrupted by reset is dropped and no ack is emitted.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE; RAM outputs 0.
- IDLE, request present: on the edge, select the owner and latch address, WR, WDATA and BE from that requester. Drive oRAM_CE=1, RD=!wr, WR=wr. Load wait counter with RAM_LATENCY-1. Go to ACCESS.
- Owner selection:
  - LS wins if iLS_REQ is high, unless iIF_REQ is high and streak == LS_MAX_STREAK; in that case IF wins.
  - Streak increments on each LS grant while iIF_REQ is high.
  - Streak clears on an IF grant, or on any LS grant while iIF_REQ is low.
- ACCESS:
  - RAM outputs are held constant. Requester inputs are ignored after the grant.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: sample iRAM_DATA into the owner's data register (LS store: write 0), pulse the owner's ACK, clear RAM outputs to 0, go to RESP.
- RESP: ACK is high for exactly this cycle. No arbitration occurs in RESP. Go to IDLE next edge.
- Requester rules:
  - The requester must drop REQ in the cycle after ACK, or present a new request there.
  - A REQ still high in IDLE is treated as a new request.
- Timing:
  - REQ seen in IDLE at cycle 0 → RAM strobes in cycles 1..RAM_LATENCY → ACK in cycle RAM_LATENCY+1 → IDLE in cycle RAM_LATENCY+2.
  - Peak throughput is one access per RAM_LATENCY+2 cycles.
- Data hold: oIF_DATA and oLS_RDATA hold their values until the next ack to the same port.
- Simultaneous IF and LS requests in IDLE: resolved by the priority rule above; the loser waits, with REQ still held.
- Misaligned addresses are not checked; address bits [1:0] are discarded.
- Only one ACK is ever high in a given cycle.

Decomposition:
- Package rv_mem_pkg:
  - state encoding (IDLE=0, ACCESS=1, RESP=2);
  - owner constants OWN_IF=0, OWN_LS=1;
  - BE_WORD=4'hF.
- Sub-module ram_wait_counter: loadable down-counter with a zero flag, reusable for future peripheral wait states.
- Arbitration and the FSM stay in the top module.

Test Plan (RAM_LATENCY=2, LS_MAX_STREAK=2 unless stated):
- Reset held, then released → all outputs 0 and oBUSY=0. Assert iRST during ACCESS of a load → outputs 0 within the same cycle; no oLS_ACK ever appears for that load.
- Single IF read, iIF_ADDR=0x0000_0010, RAM returns 0xDEAD_BEEF → oRAM_ADDR=0x04, RD=1 for exactly cycles 1-2; oIF_ACK pulse in cycle 3 with oIF_DATA=0xDEAD_BEEF.
- LS store, addr 0x20, wdata 0x1234_5678, BE=4'b0011 → oRAM_WR=1, oRAM_ADDR=0x08, oRAM_BE=4'b0011 for 2 cycles; oLS_ACK pulse with oLS_RDATA=0.
- IF and LS requested in the same cycle (load at 0x40) → LS granted first; after oLS_ACK, IF is granted on the next IDLE cycle; oIF_ACK 4 cycles after oLS_ACK.
- Fairness: iIF_REQ held high while LS issues 3 back-to-back loads → grant order LS, LS, IF, LS; the streak clears after the IF grant.
- RAM_LATENCY=1, IF requests back-to-back → one ack every 3 cycles; RAM strobes last 1 cycle each; oRAM_ADDR is stable across each strobe.
